// File: rtl/game_control_if.sv
// Datapath-facing bus of the game sequencer: state code and plot strobe go
// out, rectangle-done and collision status come back.
interface game_control_if;
    logic [3:0] cur_state;
    logic       plot;
    logic       finished_draw;
    logic       collision;

    modport master (output cur_state, plot, input finished_draw, collision);
    modport slave  (input cur_state, plot, output finished_draw, collision);
endinterface

// File: rtl/game_control.sv
// Game sequencer: frame pacing, draw sequencing with timeout, flap latching,
// game-over and restart handling. cur_state is the FSM register itself.
module game_control #(
    parameter int FRAME_TICKS  = 833333,
    parameter int DRAW_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic flap,
    game_control_if.master dp,
    output logic flap_req,
    output logic game_reset,
    output logic game_over,
    output logic draw_error,
    output logic frame_overrun
);
    typedef enum logic [3:0] {
        DRAW_BIRD     = 4'd0,
        DRAW_WALL_TOP = 4'd1,
        DRAW_WALL_BOT = 4'd2,
        CHECK         = 4'd3,
        WAIT_FRAME    = 4'd4,
        UPDATE_POS    = 4'd5,
        IDLE          = 4'd6,
        GAME_OVER     = 4'd7
    } state_t;

    state_t      state;
    logic        start_d1, flap_d1, armed;
    logic [19:0] frame_cnt;
    logic [15:0] tcnt;
    logic        frame_pending, flap_latched;

    // armed masks the first cycle after reset so a key held across reset
    // does not look like a fresh press
    logic start_rise, flap_rise;
    assign start_rise = start & ~start_d1 & armed;
    assign flap_rise  = flap  & ~flap_d1  & armed;

    logic frame_tick, in_draw, running, draw_timeout, draw_adv, leave_wait;
    assign frame_tick   = (frame_cnt == 20'(FRAME_TICKS - 1));
    assign in_draw      = (state == DRAW_BIRD) || (state == DRAW_WALL_TOP) ||
                          (state == DRAW_WALL_BOT);
    assign running      = in_draw || (state == CHECK) || (state == WAIT_FRAME) ||
                          (state == UPDATE_POS);
    assign draw_timeout = in_draw && (tcnt == 16'(DRAW_TIMEOUT - 1));
    assign draw_adv     = in_draw && (dp.finished_draw || draw_timeout);
    assign leave_wait   = (state == WAIT_FRAME) && frame_pending;

    assign dp.cur_state = state;
    assign dp.plot      = in_draw;
    assign game_over    = (state == GAME_OVER);

    // Key edge-detect registers
    always_ff @(posedge clk) begin
        if (reset) begin
            start_d1 <= 1'b0;
            flap_d1  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            start_d1 <= start;
            flap_d1  <= flap;
            armed    <= 1'b1;
        end
    end

    // Free-running frame counter, wraps at FRAME_TICKS-1
    always_ff @(posedge clk) begin
        if (reset)           frame_cnt <= '0;
        else if (frame_tick) frame_cnt <= '0;
        else                 frame_cnt <= frame_cnt + 20'd1;
    end

    // Pending frame bookkeeping; a tick landing on an unconsumed tick is dropped
    // and flagged, but a tick landing on the consuming cycle is kept
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_pending <= 1'b0;
            frame_overrun <= 1'b0;
        end else if (!running) begin
            frame_pending <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_pending <= (frame_pending & ~leave_wait) | frame_tick;
            frame_overrun <= frame_tick & frame_pending & ~leave_wait;
        end
    end

    // Per-draw-state cycle counter, restarted on every draw state entry
    always_ff @(posedge clk) begin
        if (reset)                   tcnt <= '0;
        else if (!in_draw || draw_adv) tcnt <= '0;
        else                         tcnt <= tcnt + 16'd1;
    end

    // Main sequencer with registered pulse outputs and the flap latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            game_reset   <= 1'b0;
            flap_req     <= 1'b0;
            draw_error   <= 1'b0;
            flap_latched <= 1'b0;
        end else begin
            game_reset <= 1'b0;
            flap_req   <= 1'b0;
            if (draw_timeout && !dp.finished_draw) draw_error <= 1'b1;
            case (state)
                IDLE, GAME_OVER: begin
                    flap_latched <= 1'b0;
                    if (start_rise) begin
                        state      <= WAIT_FRAME;
                        game_reset <= 1'b1;
                        draw_error <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    flap_latched <= flap_latched | flap_rise;
                    if (frame_pending) begin
                        state    <= UPDATE_POS;
                        flap_req <= flap_latched | flap_rise;
                    end
                end
                UPDATE_POS: begin
                    // consume; a press on this very cycle carries to next frame
                    flap_latched <= flap_rise;
                    state        <= DRAW_BIRD;
                end
                DRAW_BIRD: begin
                    flap_latched <= flap_latched | flap_rise;
                    if (draw_adv) state <= DRAW_WALL_TOP;
                end
                DRAW_WALL_TOP: begin
                    flap_latched <= flap_latched | flap_rise;
                    if (draw_adv) state <= DRAW_WALL_BOT;
                end
                DRAW_WALL_BOT: begin
                    flap_latched <= flap_latched | flap_rise;
                    if (draw_adv) state <= CHECK;
                end
                CHECK: begin
                    flap_latched <= flap_latched | flap_rise;
                    state        <= dp.collision ? GAME_OVER : WAIT_FRAME;
                end
                default: begin
                    flap_latched <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with FRAME_TICKS=16, DRAW_TIMEOUT=32.
// Cycle k is the k-th clock period after reset release; frame ticks fall on
// cycles 15, 31, 47, ... (k mod 16 == 15).
module tb_game_control;
    logic clk = 1'b0;
    logic reset, start, flap;
    logic flap_req, game_reset, game_over, draw_error, frame_overrun;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ovr = 0;

    game_control_if dp_if ();

    game_control #(.FRAME_TICKS(16), .DRAW_TIMEOUT(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flap          (flap),
        .dp            (dp_if.master),
        .flap_req      (flap_req),
        .game_reset    (game_reset),
        .game_over     (game_over),
        .draw_error    (draw_error),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; flap = 1'b0;
        dp_if.finished_draw = 1'b0; dp_if.collision = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        chk("rst_state", dp_if.cur_state, 6);
        chk("rst_plot", dp_if.plot, 0);
        chk("rst_game_reset", game_reset, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_draw_error", draw_error, 0);
        chk("rst_flap_req", flap_req, 0);
        chk("rst_overrun", frame_overrun, 0);
        step();                                   // 1
        chk("held_start_no_edge", dp_if.cur_state, 6);
        step(); start = 1'b0;                     // 2
        step(); step(); step(); start = 1'b1;     // 5
        chk("idle_before_start", dp_if.cur_state, 6);
        step();                                   // 6
        chk("start_state", dp_if.cur_state, 4);
        chk("game_reset_pulse", game_reset, 1);
        step();                                   // 7
        chk("game_reset_one_cycle", game_reset, 0);
        while (cyc < 16) step();
        chk("wait_until_tick", dp_if.cur_state, 4);
        step();                                   // 17
        chk("update_pos", dp_if.cur_state, 5);
        chk("no_flap_req_first", flap_req, 0);
        step();                                   // 18
        chk("draw_bird", dp_if.cur_state, 0);
        chk("plot_bird", dp_if.plot, 1);
        // three flap presses while drawing the bird
        while (cyc < 27) begin
            flap = (cyc == 19 || cyc == 21 || cyc == 23);
            step();
        end
        flap = 1'b0;
        chk("bird_hold", dp_if.cur_state, 0);
        dp_if.finished_draw = 1'b1; step(); dp_if.finished_draw = 1'b0;   // 28
        chk("wall_top", dp_if.cur_state, 1);
        chk("plot_wall_top", dp_if.plot, 1);
        while (cyc < 37) step();
        dp_if.finished_draw = 1'b1; step(); dp_if.finished_draw = 1'b0;   // 38
        chk("wall_bot", dp_if.cur_state, 2);
        chk("plot_wall_bot", dp_if.plot, 1);
        while (cyc < 47) step();
        dp_if.finished_draw = 1'b1; step(); dp_if.finished_draw = 1'b0;   // 48
        chk("check_state", dp_if.cur_state, 3);
        chk("plot_off_check", dp_if.plot, 0);
        chk("overrun_tick47", frame_overrun, 1);
        chk("no_draw_error", draw_error, 0);
        step();                                   // 49
        chk("back_to_wait", dp_if.cur_state, 4);
        chk("flap_req_not_yet", flap_req, 0);
        step();                                   // 50
        chk("pending_update", dp_if.cur_state, 5);
        chk("flap_req_once", flap_req, 1);
        step();                                   // 51
        chk("flap_req_cleared", flap_req, 0);
        // quick draws; collision high during draws must be ignored
        dp_if.collision = 1'b1; dp_if.finished_draw = 1'b1;
        step(); step(); step();                   // 54
        dp_if.finished_draw = 1'b0;
        chk("collide_check", dp_if.cur_state, 3);
        step();                                   // 55
        dp_if.collision = 1'b0;
        chk("game_over_state", dp_if.cur_state, 7);
        chk("game_over_flag", game_over, 1);
        chk("plot_off_over", dp_if.plot, 0);
        start = 1'b0;
        step(); step(); flap = 1'b1;              // 57
        step(); flap = 1'b0;                      // 58
        while (cyc < 60) step();
        start = 1'b1;
        step();                                   // 61
        chk("restart_state", dp_if.cur_state, 4);
        chk("restart_game_reset", game_reset, 1);
        chk("restart_game_over", game_over, 0);
        step(); start = 1'b0;                     // 62
        step(); step(); start = 1'b1;             // 64, rise in WAIT_FRAME
        chk("wait_pending2", dp_if.cur_state, 4);
        step();                                   // 65
        chk("update2", dp_if.cur_state, 5);
        chk("start_in_wait_ignored", game_reset, 0);
        chk("flap_in_over_dropped", flap_req, 0);
        step();                                   // 66
        dp_if.finished_draw = 1'b1; step(); dp_if.finished_draw = 1'b0;  // 67
        chk("timeout_enter_top", dp_if.cur_state, 1);
        // withhold finished_draw: both wall states time out
        while (cyc < 131) begin
            step();
            if (frame_overrun) ovr++;
            if (cyc == 98) begin
                chk("top_last_cycle", dp_if.cur_state, 1);
                chk("err_before_timeout", draw_error, 0);
            end
            if (cyc == 99) begin
                chk("timeout_advance", dp_if.cur_state, 2);
                chk("draw_error_set", draw_error, 1);
            end
        end
        chk("bot_timeout_check", dp_if.cur_state, 3);
        chk("overrun_count", ovr, 3);
        step();                                   // 132
        chk("wait_after_overrun", dp_if.cur_state, 4);
        step();                                   // 133
        chk("straight_to_update", dp_if.cur_state, 5);
        chk("draw_error_sticky", draw_error, 1);
        step();                                   // 134
        chk("draw_before_reset", dp_if.cur_state, 0);
        reset = 1'b1;
        step();                                   // 135
        chk("mid_reset_state", dp_if.cur_state, 6);
        chk("mid_reset_plot", dp_if.plot, 0);
        chk("mid_reset_game_reset", game_reset, 0);
        chk("mid_reset_draw_error", draw_error, 0);
        chk("mid_reset_game_over", game_over, 0);
        reset = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
